tag_allocator: RTL and testbench

Free-list tag allocator for the core's tracking structures (ROB/LSQ/MSHR tag pools). It keeps a registered bitmap of free tags and hands out the lowest-numbered free tag over a valid/ready port, using a `priority_encoder` instance (LSB high priority) as its selection stage. Tags come back through a single free port, and a flush restores the whole pool. A free-count output lets dispatch logic check for enough tags ahead of time.

---
 rtl/tag_allocator_if.sv | 26 ++
 rtl/tag_allocator.sv | 72 +++++++
 tb/tb_tag_allocator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tag_allocator_if.sv
// tag_allocator_if: allocate/free/flush handshake and status bundle for the tag allocator.
interface tag_allocator_if #(
    parameter int WIDTH = 16
);
    localparam int TW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    logic             alloc_valid;
    logic [TW-1:0]    alloc_tag;
    logic             alloc_ready;
    logic             free_valid;
    logic [TW-1:0]    free_tag;
    logic             flush;
    logic [WIDTH-1:0] free_mask;
    logic [CW-1:0]    free_count;
    logic             full;
    logic             empty;
    logic             err_double_free;
    modport master (
        input  alloc_valid, alloc_tag, free_mask, free_count, full, empty, err_double_free,
        output alloc_ready, free_valid, free_tag, flush
    );
    modport slave (
        output alloc_valid, alloc_tag, free_mask, free_count, full, empty, err_double_free,
        input  alloc_ready, free_valid, free_tag, flush
    );
endinterface

// File: rtl/tag_allocator.sv
// tag_allocator: free-list bitmap handing out the lowest free tag, with free port, flush and sticky double-free error.
module priority_encoder #(
    parameter int WIDTH             = 16,
    parameter bit LSB_HIGH_PRIORITY = 1
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] out_o,
    output logic                     valid_o
);
    localparam int TW = $clog2(WIDTH);
    // Scan so the highest-priority set bit is the last one written.
    always_comb begin
        out_o   = '0;
        valid_o = |in_i;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[LSB_HIGH_PRIORITY ? WIDTH-1-i : i])
                out_o = TW'(LSB_HIGH_PRIORITY ? WIDTH-1-i : i);
        end
    end
endmodule

module tag_allocator #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    tag_allocator_if.slave bus
);
    localparam int TW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] free_mask_q, free_mask_d;
    logic [CW-1:0]    free_count_q, free_count_d;
    logic             err_q, err_d;
    logic [TW-1:0]    enc_tag;
    logic             enc_valid;
    logic             alloc_fire, in_range, tag_free, free_acc, dbl_free;
    priority_encoder #(.WIDTH(WIDTH), .LSB_HIGH_PRIORITY(1'b1)) u_enc (
        .in_i   (free_mask_q),
        .out_o  (enc_tag),
        .valid_o(enc_valid)
    );
    // A tag that is already free (including the one being presented) cannot be returned.
    always_comb begin
        alloc_fire   = bus.alloc_valid & bus.alloc_ready;
        in_range     = 32'(bus.free_tag) < WIDTH;
        tag_free     = free_mask_q[bus.free_tag];
        free_acc     = bus.free_valid & in_range & ~tag_free;
        dbl_free     = bus.free_valid & (~in_range | tag_free);
        free_mask_d  = bus.flush ? '1
                     : (free_mask_q & ~(WIDTH'(alloc_fire) << enc_tag)) | (WIDTH'(free_acc) << bus.free_tag);
        free_count_d = bus.flush ? CW'(WIDTH) : free_count_q - CW'(alloc_fire) + CW'(free_acc);
        err_d        = err_q | dbl_free;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            free_mask_q  <= '1;
            free_count_q <= CW'(WIDTH);
            err_q        <= 1'b0;
        end else begin
            free_mask_q  <= free_mask_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
        end
    end
    assign bus.alloc_valid     = enc_valid & ~rst;
    assign bus.alloc_tag       = enc_tag;
    assign bus.free_mask       = free_mask_q;
    assign bus.free_count      = free_count_q;
    assign bus.full            = free_count_q == CW'(WIDTH);
    assign bus.empty           = free_count_q == '0;
    assign bus.err_double_free = err_q;
endmodule

// File: tb/tb_tag_allocator.sv
// tb_tag_allocator: directed scenarios plus random soak against a per-tag free/used scoreboard.
module tb_tag_allocator;
    localparam int W = 16;
    logic clk, rst;
    int   compared = 0;
    int   mismatched = 0;
    bit   mfree[W];
    bit   merr;
    tag_allocator_if #(.WIDTH(W)) bus ();
    tag_allocator #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest();
        for (int i = 0; i < W; i++) if (mfree[i]) return i;
        return -1;
    endfunction

    function automatic int pool_count();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(mfree[i]);
        return n;
    endfunction

    function automatic logic [31:0] pool_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < W; i++) m[i] = mfree[i];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_model();
        int low = lowest();
        chk("alloc_valid", 32'(bus.alloc_valid), 32'(low >= 0));
        if (low >= 0) chk("alloc_tag", 32'(bus.alloc_tag), low);
        chk("free_mask", 32'(bus.free_mask), pool_mask());
        chk("free_count", 32'(bus.free_count), pool_count());
        chk("full", 32'(bus.full), 32'(pool_count() == W));
        chk("empty", 32'(bus.empty), 32'(pool_count() == 0));
        chk("err_double_free", 32'(bus.err_double_free), 32'(merr));
    endtask

    task automatic model_step(input bit rdy, input bit fv, input int ft, input bit fl);
        int low = lowest();
        bit acc = 0;
        if (fl) begin
            for (int i = 0; i < W; i++) mfree[i] = 1'b1;
        end else begin
            if (fv) begin
                if (ft >= W || mfree[ft]) merr = 1'b1;
                else acc = 1'b1;
            end
            if (rdy && low >= 0) mfree[low] = 1'b0;
            if (acc) mfree[ft] = 1'b1;
        end
    endtask

    task automatic cycle(input bit rdy, input bit fv, input int ft, input bit fl);
        bus.alloc_ready = rdy;
        bus.free_valid  = fv;
        bus.free_tag    = 4'(ft);
        bus.flush       = fl;
        #1;
        check_model();
        model_step(rdy, fv, ft, fl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.alloc_ready = 0;
        bus.free_valid  = 0;
        bus.free_tag    = 0;
        bus.flush       = 0;
        @(negedge clk);
        #1;
        chk("rst_alloc_valid", 32'(bus.alloc_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W; i++) mfree[i] = 1'b1;
        merr = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("post_rst_tag", 32'(bus.alloc_tag), 0);
        chk("post_rst_count", 32'(bus.free_count), W);
        for (int i = 0; i < W; i++) begin
            chk("drain_tag", 32'(bus.alloc_tag), i);
            cycle(1, 0, 0, 0);
        end
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_valid", 32'(bus.alloc_valid), 0);
        cycle(0, 1, 9, 0);
        cycle(0, 1, 3, 0);
        chk("reuse_count", 32'(bus.free_count), 2);
        chk("reuse_mask", 32'(bus.free_mask), 32'h0208);
        chk("reuse_tag", 32'(bus.alloc_tag), 3);
        cycle(1, 0, 0, 0);
        chk("reuse_next_tag", 32'(bus.alloc_tag), 9);

        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        chk("pre_both_tag", 32'(bus.alloc_tag), 5);
        cycle(1, 1, 2, 0);
        chk("both_count", 32'(bus.free_count), 11);
        chk("both_tag", 32'(bus.alloc_tag), 2);
        chk("both_bit5", 32'(bus.free_mask[5]), 0);
        cycle(0, 1, 7, 0);
        chk("dbl_err", 32'(bus.err_double_free), 1);
        chk("dbl_count", 32'(bus.free_count), 11);
        cycle(0, 0, 0, 1);
        chk("dbl_err_flush", 32'(bus.err_double_free), 1);
        chk("flush_full", 32'(bus.full), 1);
        do_reset();
        chk("dbl_err_rst", 32'(bus.err_double_free), 0);

        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        chk("fa_mask", 32'(bus.free_mask), 32'hFFFF);
        chk("fa_count", 32'(bus.free_count), W);
        chk("fa_full", 32'(bus.full), 1);
        chk("fa_tag", 32'(bus.alloc_tag), 0);

        for (int i = 0; i < 3000; i++) begin
            bit fl = ($urandom_range(0, 49) == 0);
            bit fv = !fl && ($urandom_range(0, 2) != 0);
            if (i % 300 == 299) do_reset();
            cycle(bit'($urandom_range(0, 1)), fv, int'($urandom_range(0, W - 1)), fl);
        end
        check_model();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
